serial_add_seq: RTL and testbench
=================================

Name: serial_add_seq

Overview:
- Multi-cycle sequencer that adds two WIDTH-bit operands using one shared 2-bit full-adder slice.
- Each cycle processes one 2-bit digit, LSB digit first, and carries into the next digit through a carry register.
- Uses the team's 2-bit adder datapath as the shared arithmetic resource.
- Exposes a start/busy/done handshake to the surrounding lab top-level.

Parameters:
- WIDTH, 8, operand/sum width in bits; must be even and >= 2 (elaboration error otherwise).
- DIGITS, WIDTH/2, derived (localparam), number of RUN cycles.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  request a new addition; sampled only in IDLE or DONE.
- abort  in  1  synchronous cancel of an addition in progress.
- a  in  WIDTH  operand A; latched when start is accepted.
- b  in  WIDTH  operand B; latched when start is accepted.
- cin  in  1  carry into digit 0; latched when start is accepted.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; sum/cout valid.
- sum  out  WIDTH  registered result; holds until the next accepted start.
- cout  out  1  registered carry out of the top digit.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy=0, done=0, sum=0, cout=0; operand registers, carry register and digit counter cleared.
- States: IDLE, RUN, DONE. Transitions:
  - IDLE: start=1 -> RUN. On the same edge: latch a, b; carry<=cin; cnt<=0; sum<=0; cout<=0.
  - RUN: abort=1 -> IDLE; sum keeps its partial digits; cout=0; no done.
  - RUN: cnt==DIGITS-1 -> DONE; cout<=slice carry-out.
  - RUN: otherwise cnt<=cnt+1.
  - DONE: start=1 -> RUN, same latch actions as IDLE. Otherwise -> IDLE.
- RUN cycle k:
  - slice inputs are a_q[2k+1:2k], b_q[2k+1:2k] and the carry register.
  - slice 2-bit sum -> sum[2k+1:2k]; slice carry-out -> carry register.
  - The slice is purely combinational; each digit is registered at the end of its cycle.
- Latency: start accepted at edge E0 -> busy high for DIGITS cycles -> done=1 in cycle DIGITS+1 after E0. WIDTH=8: done is the 5th cycle after the start edge.
- Throughput: start asserted during DONE begins the next add with no idle gap. Back-to-back period is DIGITS+1 cycles.
- Outputs are decoded from state registers only (Moore): busy=(state==RUN), done=(state==DONE).
- Boundary conditions:
  - start during RUN is ignored, with no queuing.
  - abort outside RUN has no effect.
  - abort and last-digit in the same cycle: abort wins, no done.
  - start and abort together in IDLE/DONE: start wins.
  - Operand inputs may change freely after acceptance.
  - rst_n asserted mid-RUN: immediate return to IDLE with all outputs 0.
- Arithmetic: unsigned. {cout,sum} = a + b + cin, exact for all inputs. cnt width = clog2(DIGITS), minimum 1.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the slice width constant DIGIT_W=2.
- One sub-module: adder2_cin.
  - Purely combinational 2-bit ripple adder with carry in.
  - Ports: x[1:0], y[1:0], ci -> s[1:0], co.
  - Built from two full-adder bit stages, gate-level like the existing lab adders.
- serial_add_seq contains the FSM, the counter, the operand/carry/sum registers and the digit mux.

Test Plan:
- WIDTH=8; a=0x5A, b=0x3C, cin=0, start pulse:
  - busy high for 4 cycles, done in cycle 5.
  - sum=0x96, cout=0.
- a=0xFF, b=0x01, cin=0: carry ripples through all 4 digits; sum=0x00, cout=1. Also a=0xFF, b=0x00, cin=1: sum=0x00, cout=1.
- Start held high continuously with new operands each DONE cycle:
  - adds complete every 5 cycles.
  - start pulses while busy are ignored; operands changed during RUN do not affect the result.
- abort raised in the 2nd RUN cycle of 0xAA+0x55:
  - return to IDLE next cycle, no done pulse, cout=0.
  - the next start runs normally.
- rst_n dropped asynchronously mid-RUN (between clock edges):
  - busy, done, sum and cout go to 0 immediately.
  - after release, start with 0x80+0x80 gives sum=0x00, cout=1.
- Random sweep of 1000 a/b/cin triples vs reference model {cout,sum}=a+b+cin, checking done timing on every transaction.

Source files
------------

// File: rtl/serial_add_seq_pkg.sv
// rtl/serial_add_seq_pkg.sv - shared constants and state encoding for the digit-serial adder
//
// Purpose: state encoding and digit width shared by serial_add_seq and adder2_cin.
// Contents:
//   DIGIT_W - width of one digit handled by the shared adder slice per cycle
//   state_t - sequencer states IDLE / RUN / DONE
package serial_add_seq_pkg;

  localparam int DIGIT_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_add_seq_adder2_cin.sv
// rtl/serial_add_seq_adder2_cin.sv - combinational 2-bit ripple adder with carry in
//
// Purpose: the shared arithmetic slice, two gate-level full-adder stages.
// Ports:
//   x, y : 2-bit addends
//   ci   : carry in
//   s    : 2-bit sum
//   co   : carry out of bit 1
module adder2_cin
  import serial_add_seq_pkg::*;
(
  input  logic [DIGIT_W-1:0] x,
  input  logic [DIGIT_W-1:0] y,
  input  logic               ci,
  output logic [DIGIT_W-1:0] s,
  output logic               co
);

  logic p0, p1;
  logic c1;

  // bit 0 full adder
  assign p0   = x[0] ^ y[0];
  assign s[0] = p0 ^ ci;
  assign c1   = (x[0] & y[0]) | (p0 & ci);

  // bit 1 full adder
  assign p1   = x[1] ^ y[1];
  assign s[1] = p1 ^ c1;
  assign co   = (x[1] & y[1]) | (p1 & c1);

endmodule

// File: rtl/serial_add_seq.sv
// rtl/serial_add_seq.sv - digit-serial adder sequencer around one shared 2-bit slice
//
// Purpose: adds two WIDTH-bit unsigned operands one 2-bit digit per cycle,
// LSB digit first, rippling the carry through a carry register.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   start : request a new addition (accepted in IDLE or DONE)
//   abort : cancel an addition in progress (RUN only)
//   a, b  : operands, latched when start is accepted
//   cin   : carry into digit 0, latched when start is accepted
//   busy  : high while in RUN
//   done  : one-cycle pulse, sum/cout valid
//   sum   : registered result, held until the next accepted start
//   cout  : registered carry out of the top digit
module serial_add_seq
  import serial_add_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int DIGITS = WIDTH / DIGIT_W;
  localparam int CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

  generate
    if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
      $error("serial_add_seq: WIDTH must be even and >= 2");
    end
  endgenerate

  state_t             state;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   sum_q;
  logic               carry_q;
  logic               cout_q;
  logic [CNT_W-1:0]   cnt;

  logic [DIGIT_W-1:0] a_dig;
  logic [DIGIT_W-1:0] b_dig;
  logic [DIGIT_W-1:0] slice_s;
  logic               slice_co;

  // Digit mux: select the operand digit addressed by the counter.
  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (cnt == CNT_W'(i)) begin
        a_dig = a_q[DIGIT_W*i +: DIGIT_W];
        b_dig = b_q[DIGIT_W*i +: DIGIT_W];
      end
    end
  end

  adder2_cin u_slice (
    .x  (a_dig),
    .y  (b_dig),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            // start beats a simultaneous abort: abort only acts in RUN
            state   <= RUN;
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            cnt     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (abort) begin
            // Abort wins over the last digit; the current digit is not written.
            state  <= IDLE;
            cout_q <= 1'b0;
          end else begin
            for (int i = 0; i < DIGITS; i++) begin
              if (cnt == CNT_W'(i)) begin
                sum_q[DIGIT_W*i +: DIGIT_W] <= slice_s;
              end
            end
            carry_q <= slice_co;
            if (cnt == LAST_CNT) begin
              state  <= DONE;
              cout_q <= slice_co;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Moore outputs decoded straight from the state register.
  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_seq.sv
// tb/tb_serial_add_seq.sv - directed and random self-checking bench for serial_add_seq
module tb_serial_add_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;

  int checks;
  int errors;

  serial_add_seq #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .abort (abort),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for done; returns the number of edges after the start edge.
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic run_add(input logic [7:0] av, input logic [7:0] bv, input logic ci,
                         input logic [7:0] es, input logic ec, input logic ab,
                         input string tag);
    int n;
    a = av; b = bv; cin = ci; start = 1'b1; abort = ab;
    tick();
    start = 1'b0; abort = 1'b0;
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    check({tag, "_busy"}, busy, 1);
    wait_done(n);
    check({tag, "_lat"}, n, 4);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, cout, ec);
    tick();
    check({tag, "_idle"}, {busy, done}, 2'b00);
  endtask

  logic [7:0] ta [3] = '{8'h11, 8'h40, 8'h7F};
  logic [7:0] tb [3] = '{8'h22, 8'hC0, 8'h7F};
  logic       tc [3] = '{1'b0, 1'b1, 1'b0};
  logic [7:0] ts [3] = '{8'h33, 8'h01, 8'hFE};
  logic       tco[3] = '{1'b0, 1'b1, 1'b0};

  initial begin
    int n;
    int seen_done;
    logic [7:0] ra, rb;
    logic       rc;
    logic [8:0] ref_v;

    checks = 0; errors = 0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; a = '0; b = '0; cin = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);

    // Latency detail for the first add
    a = 8'h5A; b = 8'h3C; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("lat_busy", busy, 1);
      check("lat_nodone", done, 0);
      tick();
    end
    check("lat_done", done, 1);
    check("lat_busy_off", busy, 0);
    check("5a3c_sum", sum, 8'h96);
    check("5a3c_cout", cout, 0);
    tick();
    check("done_pulse", done, 0);

    run_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "ff01");
    run_add(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, "ff00c");
    run_add(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b1, "start_abort");

    // Back-to-back with start held high
    start = 1'b1; a = ta[0]; b = tb[0]; cin = tc[0];
    tick();
    for (int j = 0; j < 3; j++) begin
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      wait_done(n);
      check("b2b_lat", n, 4);
      check("b2b_sum", sum, ts[j]);
      check("b2b_cout", cout, tco[j]);
      if (j < 2) begin
        a = ta[j+1]; b = tb[j+1]; cin = tc[j+1];
      end else begin
        start = 1'b0;
      end
      tick();
      check("b2b_next", busy, (j < 2) ? 1 : 0);
    end

    // Abort in the 2nd RUN cycle
    a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_cout", cout, 0);
    check("abort_sum", sum, 8'h03);
    seen_done = 0;
    for (int k = 0; k < 6; k++) begin
      if (done) seen_done = 1;
      tick();
    end
    check("abort_nodone", seen_done, 0);
    run_add(8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0, "after_abort");

    // Asynchronous reset mid-RUN
    a = 8'h5A; b = 8'h3C; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_sum", sum, 0);
    check("arst_cout", cout, 0);
    tick();
    rst_n = 1'b1;
    tick();
    run_add(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b0, "8080");

    // Random sweep against the reference sum
    for (int t = 0; t < 1000; t++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      ref_v = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      run_add(ra, rb, rc, ref_v[7:0], ref_v[8], 1'b0, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
